// File: rtl/fetch_unit.sv
// fetch_unit: req/ack instruction fetch with valid/ready issue and next-PC select; FETCH_MISALIGN_TRAP_EN enables misalign trap
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic        misalign,
  output logic [31:0] trap_epc
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2;
  logic [1:0]  state;
  logic [31:0] next_pc, redirect;
  logic        take;
  assign PCPlus4     = PC + 32'd4;
  assign imem_req    = state == REQ;
  assign imem_addr   = PC;
  assign instr_valid = state == VALID;
  assign take        = state == VALID && instr_ready;
  always_comb next_pc = PCSrc == 2'b01 ? PC + ImmExt :
                        PCSrc == 2'b10 ? ALUResult & 32'hFFFF_FFFE : PC + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap;
  assign trap     = take && |next_pc[1:0];
  assign redirect = trap ? TRAP_VECTOR : next_pc;
  always_ff @(posedge clk)
    if (reset) begin
      misalign <= 1'b0;
      trap_epc <= 32'd0;
    end else begin
      misalign <= trap;
      if (trap) trap_epc <= next_pc;
    end
`else
  assign redirect = next_pc & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
  assign trap_epc = 32'd0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      PC    <= RESET_PC;
      Instr <= 32'h0000_0013;
    end else begin
      case (state)
        IDLE:  state <= REQ;
        REQ:   if (imem_ack) begin
                 Instr <= imem_rdata;
                 state <= VALID;
               end
        VALID: if (instr_ready) begin
                 PC    <= redirect;
                 state <= REQ;
               end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (both FETCH_MISALIGN_TRAP_EN builds)
module tb_fetch_unit;
  logic        clk = 0, reset = 0, imem_ack = 0, instr_ready = 0;
  logic [31:0] imem_rdata = 0, ImmExt = 0, ALUResult = 0;
  logic [1:0]  PCSrc = 0;
  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, Instr, PC, PCPlus4, trap_epc;
  int tests = 0, fails = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instr(Instr), .PC(PC),
    .PCPlus4(PCPlus4), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .misalign(misalign), .trap_epc(trap_epc));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; imem_ack = 0; instr_ready = 0;
    tick;
    reset = 0;
  endtask

  // One transaction: wait for req, ack after `waits` cycles, then retire with the given next-PC inputs.
  task automatic do_fetch(input logic [31:0] rdata, input int waits, input logic [1:0] src,
                          input logic [31:0] imm, input logic [31:0] alu,
                          output logic [31:0] addr, output logic vld, output logic [31:0] ins,
                          output int cycles, output logic timeout);
    cycles = 0; timeout = 0;
    while (!imem_req && cycles < 10) begin tick; cycles++; end
    if (!imem_req) timeout = 1;
    addr = imem_addr;
    repeat (waits) begin tick; cycles++; end
    imem_ack = 1; imem_rdata = rdata;
    tick; cycles++;
    imem_ack = 0; imem_rdata = 32'hDEAD_BEEF;
    vld = instr_valid; ins = Instr;
    instr_ready = 1; PCSrc = src; ImmExt = imm; ALUResult = alu;
    tick; cycles++;
    instr_ready = 0; PCSrc = 0;
  endtask

  task automatic test_reset;
    reset = 1; tick; reset = 0;
    tests++; if (PC !== 32'h0 || PCPlus4 !== 32'h4) begin fails++; $display("FAIL reset_pc PC=%h PCPlus4=%h want 0/4", PC, PCPlus4); end
    tests++; if (Instr !== 32'h13) begin fails++; $display("FAIL reset_instr got %h want 00000013", Instr); end
    tests++; if (instr_valid !== 0 || imem_req !== 0 || misalign !== 0 || trap_epc !== 0) begin
      fails++; $display("FAIL reset_ctrl valid=%b req=%b mis=%b epc=%h want 0", instr_valid, imem_req, misalign, trap_epc); end
    imem_ack = 1; tick; imem_ack = 0;
    tests++; if (imem_req !== 1 || instr_valid !== 0) begin fails++; $display("FAIL idle_ack req=%b valid=%b want 1/0", imem_req, instr_valid); end
  endtask

  task automatic test_sequential;
    logic [31:0] a, ins; logic v, to; int c;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      do_fetch(32'h1000_0000 + i, 1, 2'b00, 0, 0, a, v, ins, c, to);
      tests++; if (to || a !== 32'(i * 4)) begin fails++; $display("FAIL seq_addr[%0d] got %h want %h", i, a, i * 4); end
      tests++; if (v !== 1 || ins !== 32'h1000_0000 + i) begin fails++; $display("FAIL seq_instr[%0d] valid=%b instr=%h want 1/%h", i, v, ins, 32'h1000_0000 + i); end
      if (i > 0) begin
        tests++; if (c !== 3) begin fails++; $display("FAIL seq_cycles[%0d] got %0d want 3", i, c); end
      end
    end
  endtask

  task automatic test_branch_jalr;
    logic [31:0] a, ins; logic v, to; int c;
    do_reset;
    do_fetch(32'h1, 0, 2'b01, 32'h40, 0, a, v, ins, c, to);
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL jal_addr got %h want 00000040", imem_addr); end
    do_fetch(32'h2, 0, 2'b01, 32'hFFFF_FFF0, 0, a, v, ins, c, to);
    tests++; if (imem_addr !== 32'h30) begin fails++; $display("FAIL branch_back got %h want 00000030", imem_addr); end
    do_fetch(32'h3, 0, 2'b10, 0, 32'h81, a, v, ins, c, to);
    tests++; if (imem_addr !== 32'h80) begin fails++; $display("FAIL jalr_addr got %h want 00000080", imem_addr); end
    do_fetch(32'h4, 0, 2'b11, 0, 0, a, v, ins, c, to);
    tests++; if (imem_addr !== 32'h84) begin fails++; $display("FAIL src11_addr got %h want 00000084", imem_addr); end
  endtask

  task automatic test_wait_states;
    logic [31:0] pc0;
    do_reset;
    tick;
    pc0 = PC;
    instr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (imem_req !== 1 || instr_valid !== 0) begin fails++; $display("FAIL wait_req[%0d] req=%b valid=%b want 1/0", i, imem_req, instr_valid); end
      tick;
    end
    instr_ready = 0;
    imem_ack = 1; imem_rdata = 32'hCAFE_0001; tick; imem_ack = 0; imem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (instr_valid !== 1 || imem_req !== 0 || Instr !== 32'hCAFE_0001 || PC !== pc0) begin
        fails++; $display("FAIL hold[%0d] valid=%b req=%b instr=%h pc=%h want 1/0/cafe0001/%h", i, instr_valid, imem_req, Instr, PC, pc0); end
      imem_ack = 1; tick; imem_ack = 0;
    end
    instr_ready = 1; tick; instr_ready = 0;
    tests++; if (imem_req !== 1 || PC !== pc0 + 4) begin fails++; $display("FAIL after_hold req=%b pc=%h want 1/%h", imem_req, PC, pc0 + 4); end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] a, ins; logic v, to; int c;
    do_reset;
    do_fetch(32'h5, 0, 2'b01, 32'h200, 0, a, v, ins, c, to);
    tick;
    reset = 1; tick; reset = 0;
    tests++; if (imem_req !== 0 || PC !== 32'h0) begin fails++; $display("FAIL rst_wait req=%b pc=%h want 0/0", imem_req, PC); end
    imem_ack = 1; imem_rdata = 32'hBAD0_BAD0; tick; imem_ack = 0;
    tests++; if (instr_valid !== 0 || Instr !== 32'h13 || PC !== 32'h0) begin
      fails++; $display("FAIL stale_ack valid=%b instr=%h pc=%h want 0/00000013/0", instr_valid, Instr, PC); end
  endtask

  task automatic test_wrap_misalign;
    logic [31:0] a, ins; logic v, to; int c;
    do_reset;
    do_fetch(32'h6, 0, 2'b01, 32'hFFFF_FFFC, 0, a, v, ins, c, to);
    tests++; if (imem_addr !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin fails++; $display("FAIL top_pc addr=%h p4=%h want fffffffc/0", imem_addr, PCPlus4); end
    do_fetch(32'h7, 0, 2'b00, 0, 0, a, v, ins, c, to);
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
    do_fetch(32'h8, 0, 2'b01, 32'h10, 0, a, v, ins, c, to);
    tests++; if (misalign !== 0) begin fails++; $display("FAIL aligned_mis got %b want 0", misalign); end
    do_fetch(32'h9, 0, 2'b01, 32'h2, 0, a, v, ins, c, to);
`ifdef FETCH_MISALIGN_TRAP_EN
    tests++; if (misalign !== 1 || trap_epc !== 32'h12 || imem_addr !== 32'h100) begin
      fails++; $display("FAIL trap mis=%b epc=%h addr=%h want 1/00000012/00000100", misalign, trap_epc, imem_addr); end
    tick;
    tests++; if (misalign !== 0 || trap_epc !== 32'h12) begin fails++; $display("FAIL trap_pulse mis=%b epc=%h want 0/00000012", misalign, trap_epc); end
`else
    tests++; if (misalign !== 0 || trap_epc !== 32'h0 || imem_addr !== 32'h10) begin
      fails++; $display("FAIL align_down mis=%b epc=%h addr=%h want 0/0/00000010", misalign, trap_epc, imem_addr); end
    do_fetch(32'hA, 0, 2'b10, 0, 32'h83, a, v, ins, c, to);
    tests++; if (imem_addr !== 32'h80) begin fails++; $display("FAIL jalr_align got %h want 00000080", imem_addr); end
`endif
  endtask

  initial begin
    tick;
    test_reset;
    test_sequential;
    test_branch_jalr;
    test_wait_states;
    test_reset_mid_wait;
    test_wrap_misalign;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
